// File: rtl/mdu_iter_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// master: execute-stage requester/consumer. slave: the unit itself.
interface mdu_iter_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic            is_w;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, funct3, is_w, src1, src2, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, funct3, is_w, src1, src2, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per cycle, with
// valid/ready handshakes, W-form support (XLEN==64) and flush.
// Optional macro MDU_EARLY_OUT_EN: multiply finishes early once the
// remaining multiplier bits are all zero.
module mdu_iter #(
  parameter int unsigned XLEN = 64
) (
  input logic        clk,
  input logic        rst,
  mdu_iter_if.slave  bus
);

  localparam int unsigned CW  = $clog2(XLEN + 1);
  localparam int unsigned WSH = XLEN - 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nx;

  // Latched request
  logic [XLEN-1:0]   a_q, b_q;
  logic [2:0]        f3_q;
  logic              w_q;
  logic [CW-1:0]     n_q;

  // Iteration datapath
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   mcand_q, mplier_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   quo_q, rem_q, dvsr_q;
  logic              neg_q;
  logic [XLEN-1:0]   result_q;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v;
    return r;
  endfunction

  logic accept;
  logic w_in;

  assign accept = bus.in_valid && (state == S_IDLE) && !bus.flush;
  assign w_in   = (XLEN == 64) && bus.is_w;

  // Operand preparation: width adjust, magnitudes, sign bookkeeping, special divides
  logic            s1_signed, s2_signed, w_sext;
  logic [XLEN-1:0] a_adj, b_adj, mag1, mag2, most_neg, special_res;
  logic            sign1, sign2, div0, ovf, special, neg_nx;

  always_comb begin
    s1_signed = (f3_q == 3'b001) || (f3_q == 3'b010) ||
                (f3_q == 3'b100) || (f3_q == 3'b110);
    s2_signed = (f3_q == 3'b001) || (f3_q == 3'b100) || (f3_q == 3'b110);
    w_sext    = !((f3_q == 3'b101) || (f3_q == 3'b111));
    a_adj     = a_q;
    b_adj     = b_q;
    if (w_q) begin
      a_adj = w_sext ? sext32(a_q[31:0]) : zext32(a_q[31:0]);
      b_adj = w_sext ? sext32(b_q[31:0]) : zext32(b_q[31:0]);
    end
    sign1    = s1_signed && a_adj[XLEN-1];
    sign2    = s2_signed && b_adj[XLEN-1];
    mag1     = sign1 ? ('0 - a_adj) : a_adj;
    mag2     = sign2 ? ('0 - b_adj) : b_adj;
    most_neg = w_q ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div0     = f3_q[2] && (b_adj == '0);
    ovf      = f3_q[2] && s2_signed && (a_adj == most_neg) && (b_adj == '1);
    special  = div0 || ovf;
    if (f3_q[1])
      special_res = div0 ? (w_q ? sext32(a_adj[31:0]) : a_adj) : '0;
    else
      special_res = div0 ? '1 : a_adj;
    // Remainder takes the dividend sign; quotient and products take sign1^sign2
    neg_nx = (f3_q[2] && f3_q[1]) ? sign1 : (sign1 ^ sign2);
  end

  // One shift-add multiply step, optionally followed by a final alignment
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step, mul_next;
  logic              mul_early, mul_done;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    mul_step = {mul_sum, acc_q[XLEN-1:1]};
`ifdef MDU_EARLY_OUT_EN
    // With no multiplier bits left, the remaining iterations are pure shifts
    mul_early = (mplier_q[XLEN-1:1] == '0);
    mul_next  = mul_early ? (mul_step >> (cnt_q - CW'(1))) : mul_step;
`else
    mul_early = 1'b0;
    mul_next  = mul_step;
`endif
    mul_done = mul_early || (cnt_q == CW'(1));
  end

  // One restoring-division step
  logic [XLEN:0]   trial, diff;
  logic            ge;
  logic [XLEN-1:0] rem_nx, quo_nx;

  always_comb begin
    trial  = {rem_q, quo_q[XLEN-1]};
    diff   = trial - {1'b0, dvsr_q};
    ge     = trial >= {1'b0, dvsr_q};
    rem_nx = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
    quo_nx = {quo_q[XLEN-2:0], ge};
  end

  // Final sign application and word selection
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   dv, fix_res;

  always_comb begin
    // W products sit 32 bits higher in the accumulator after 32 right shifts
    prod   = w_q ? (acc_q >> WSH) : acc_q;
    prod_s = neg_q ? ('0 - prod) : prod;
    dv     = f3_q[1] ? rem_q : quo_q;
    if (f3_q[2])
      fix_res = neg_q ? ('0 - dv) : dv;
    else if (f3_q[1:0] == 2'b00)
      fix_res = prod_s[XLEN-1:0];
    else
      fix_res = prod_s[2*XLEN-1:XLEN];
    if (w_q)
      fix_res = sext32(fix_res[31:0]);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_PREP;
      S_PREP: begin
        if (special)      state_nx = S_DONE;
        else if (f3_q[2]) state_nx = S_DIV;
        else              state_nx = S_MUL;
      end
      S_MUL:  if (mul_done) state_nx = S_FIX;
      S_DIV:  if (cnt_q == CW'(1)) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: if (bus.out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (bus.flush) state_nx = S_IDLE;
  end

  // Handshake outputs
  always_comb begin
    bus.in_ready  = (state == S_IDLE);
    bus.out_valid = (state == S_DONE);
    bus.busy      = (state != S_IDLE);
    bus.result    = result_q;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      w_q      <= 1'b0;
      n_q      <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q  <= bus.src1;
            b_q  <= bus.src2;
            f3_q <= bus.funct3;
            w_q  <= w_in;
            n_q  <= w_in ? CW'(32) : CW'(XLEN);
          end
        end
        S_PREP: begin
          neg_q    <= neg_nx;
          cnt_q    <= n_q;
          mcand_q  <= mag1;
          mplier_q <= w_q ? zext32(mag2[31:0]) : mag2;
          acc_q    <= '0;
          // W dividends are pre-aligned so the next bit is always the MSB
          quo_q    <= w_q ? (mag1 << WSH) : mag1;
          rem_q    <= '0;
          dvsr_q   <= mag2;
          if (special && !bus.flush) result_q <= special_res;
        end
        S_MUL: begin
          acc_q    <= mul_next;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
        end
        S_DIV: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - CW'(1);
        end
        S_FIX: begin
          if (!bus.flush) result_q <= fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (XLEN=64): directed vector table,
// randomized ops against an arithmetic reference model, and hand-written
// flush/reset sequences.
module tb_mdu_iter;

  localparam int unsigned XLEN = 64;
`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_iter_if #(.XLEN(XLEN)) bus ();
  mdu_iter #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned checks = 0;
  int unsigned failures = 0;

  typedef struct {
    string       nm;
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int unsigned lat;
    int unsigned hold;
    bit          poke;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%016h required=0x%016h", nm, act, exp);
    end
  endtask

  // Reference result from the RISC-V M-extension rules
  function automatic logic [63:0] ref_mdu(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [31:0]  a32, b32, r32;
    logic [63:0]  r64;
    logic [127:0] x, y, p;
    a32 = a[31:0];
    b32 = b[31:0];
    r32 = '0;
    r64 = '0;
    if (w) begin
      case (f3)
        3'd0: r32 = a32 * b32;
        3'd4: if (b32 == 0) r32 = '1;
              else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
              else r32 = $signed(a32) / $signed(b32);
        3'd5: r32 = (b32 == 0) ? 32'hFFFF_FFFF : a32 / b32;
        3'd6: if (b32 == 0) r32 = a32;
              else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = '0;
              else r32 = $signed(a32) % $signed(b32);
        3'd7: r32 = (b32 == 0) ? a32 : a32 % b32;
        default: r32 = '0;
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (f3)
      3'd0: r64 = a * b;
      3'd1: begin x = {{64{a[63]}}, a}; y = {{64{b[63]}}, b}; p = x * y; r64 = p[127:64]; end
      3'd2: begin x = {{64{a[63]}}, a}; y = {64'd0, b};       p = x * y; r64 = p[127:64]; end
      3'd3: begin x = {64'd0, a};       y = {64'd0, b};       p = x * y; r64 = p[127:64]; end
      3'd4: if (b == 0) r64 = '1;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) r64 = a;
            else r64 = $signed(a) / $signed(b);
      3'd5: r64 = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      3'd6: if (b == 0) r64 = a;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) r64 = '0;
            else r64 = $signed(a) % $signed(b);
      default: r64 = (b == 0) ? a : a % b;
    endcase
    return r64;
  endfunction

  // Reference latency: edges after the accepting edge until out_valid
  function automatic int unsigned ref_lat(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    bit special;
    special = 1'b0;
    if (f3[2]) begin
      if (w) special = (b[31:0] == 0) || ((f3 == 3'd4 || f3 == 3'd6) &&
                       a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
      else   special = (b == 0) || ((f3 == 3'd4 || f3 == 3'd6) &&
                       a == 64'h8000_0000_0000_0000 && b == '1);
    end
    return special ? 1 : (w ? 34 : 66);
  endfunction

  task automatic check_lat(input string nm, input logic [2:0] f3,
                           input int unsigned lat, input int unsigned exp_lat);
    if (EARLY && !f3[2])
      check(nm, 64'((lat >= 3 && lat <= exp_lat) ? 1 : 0), 64'd1);
    else
      check(nm, 64'(lat), 64'(exp_lat));
  endtask

  // Full transaction: issue, wait for result, optional stall in DONE, handshake
  task automatic run_op(input string nm, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int unsigned exp_lat,
                        input int unsigned hold, input bit poke);
    int unsigned lat;
    bit rdy_seen;
    @(negedge clk);
    check({nm, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.funct3   = f3;
    bus.is_w     = w;
    bus.src1     = a;
    bus.src2     = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    check({nm, "_in_ready_busy"}, 64'(rdy_seen), 64'd0);
    check({nm, "_result"}, bus.result, exp);
    check_lat({nm, "_latency"}, f3, lat, exp_lat);
    for (int unsigned k = 0; k < hold; k++) begin
      @(negedge clk);
      if (poke) begin
        bus.in_valid = 1'b1;
        bus.funct3   = 3'd4;
        bus.src1     = 64'd5;
        bus.src2     = 64'd1;
      end
      @(posedge clk); #1;
      check({nm, "_hold_result"}, bus.result, exp);
      check({nm, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({nm, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({nm, "_post_valid"}, 64'(bus.out_valid), 64'd0);
    check({nm, "_post_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic add(input string nm, input logic [2:0] f3, input logic w,
                     input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                     input int unsigned lat, input int unsigned hold, input bit poke);
    vec_t v;
    v.nm = nm; v.f3 = f3; v.w = w; v.a = a; v.b = b; v.exp = exp;
    v.lat = lat; v.hold = hold; v.poke = poke;
    vecs.push_back(v);
  endtask

  function automatic logic [63:0] rand_val();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0: v = '0;
      1: v = 64'd1;
      2: v = '1;
      3: v = 64'h8000_0000_0000_0000;
      4: v = {$urandom(), 32'h8000_0000};
      5: begin
        v = 64'($urandom_range(0, 40));
        if ($urandom_range(0, 1) == 1) v = '0 - v;
      end
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a, b;

    rst = 1'b0;
    bus.in_valid = 1'b0; bus.funct3 = '0; bus.is_w = 1'b0;
    bus.src1 = '0; bus.src2 = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_result", bus.result, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    add("mul_neg",    3'd0, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, 0, 0);
    add("divu_zero",  3'd5, 0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
    add("remu_zero",  3'd7, 0, 64'd100, 64'd0, 64'd100, 1, 0, 0);
    add("div_ovf",    3'd4, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0, 0);
    add("rem_ovf",    3'd6, 0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0, 0);
    add("divw",       3'd4, 1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, 0, 0);
    add("remw",       3'd6, 1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0, 0);
    add("mulhu_max",  3'd3, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 5, 1);
    add("mulh_m1",    3'd1, 0, '1, '1, 64'd0, 66, 0, 0);
    add("mulhsu",     3'd2, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 66, 1, 0);
    add("divuw_zero", 3'd5, 1, 64'h1234_5678_8000_0000, 64'hABCD_0000_0000_0000, '1, 1, 0, 0);
    add("remuw_zero", 3'd7, 1, 64'h1234_5678_8000_0000, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 1, 0, 0);
    add("divw_ovf",   3'd4, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0, 0);
    add("rem_neg",    3'd6, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 66, 0, 0);
    add("div_1000_7", 3'd4, 0, 64'd1000, 64'd7, 64'd142, 66, 0, 0);
    add("mulw",       3'd0, 1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0, 0);
    add("remuw",      3'd7, 1, 64'hFFFF_FFFF_0000_000A, 64'd3, 64'd1, 34, 0, 0);

    foreach (vecs[i])
      run_op(vecs[i].nm, vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat, vecs[i].hold, vecs[i].poke);

    for (int i = 0; i < 80; i++) begin
      f3 = 3'($urandom_range(0, 7));
      w  = ($urandom_range(0, 1) == 1) && (f3 == 3'd0 || f3[2]);
      a  = rand_val();
      b  = rand_val();
      run_op("rand", f3, w, a, b, ref_mdu(f3, w, a, b), ref_lat(f3, w, a, b),
             $urandom_range(0, 2), 1'b0);
    end

    // Flush at edge 10 of a divide: nothing is ever delivered
    @(negedge clk);
    bus.in_valid = 1'b1; bus.funct3 = 3'd4; bus.is_w = 1'b0;
    bus.src1 = 64'd1000; bus.src2 = 64'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    repeat (9) begin
      @(posedge clk); #1;
      if (bus.out_valid) n++;
    end
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_mid_valid", 64'(bus.out_valid), 64'd0);
    check("flush_mid_ready", 64'(bus.in_ready), 64'd1);
    check("flush_mid_busy", 64'(bus.busy), 64'd0);
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_valid) n++;
    end
    check("flush_mid_never_valid", 64'(n), 64'd0);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd0;
    bus.src1 = 64'd3; bus.src2 = 64'd5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("flush_idle_busy", 64'(bus.busy), 64'd0);
    check("flush_idle_ready", 64'(bus.in_ready), 64'd1);

    // Flush in DONE wins over a simultaneous out_ready; result is retained
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("fdone_valid", 64'(bus.out_valid), 64'd1);
    check("fdone_result", bus.result, 64'd15);
    @(negedge clk);
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    check("fdone_post_valid", 64'(bus.out_valid), 64'd0);
    check("fdone_post_ready", 64'(bus.in_ready), 64'd1);
    check("fdone_post_result", bus.result, 64'd15);

    // Flush during FIX (edge 66 of a divide) suppresses the result update
    @(negedge clk);
    bus.in_valid = 1'b1; bus.funct3 = 3'd4; bus.src1 = 64'd1000; bus.src2 = 64'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (65) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("ffix_valid", 64'(bus.out_valid), 64'd0);
    check("ffix_ready", 64'(bus.in_ready), 64'd1);
    check("ffix_result", bus.result, 64'd15);

    // Asynchronous reset mid-operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_ready", 64'(bus.in_ready), 64'd1);
    check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_result", bus.result, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op("after_rst", 3'd5, 1'b0, 64'd1000, 64'd7, 64'd142, 66, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative, multi-cycle RISC-V M-extension multiply/divide unit with valid/ready handshakes on input and output.
- Parametrised successor of the single-cycle combinational MDU used by the execute stage.
- Sits beside the ALU in the execute stage. The EXU stalls on in_ready/out_valid instead of resolving mul/div in one cycle.
- Supports OP and OP_32 (W) forms, divide-by-zero and signed-overflow rules, and flush.

Parameters:
- XLEN, 64, datapath width; 32 or 64. W ops exist only when XLEN==64.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept; high only in IDLE
- funct3  in  3  MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU encoding (000..111)
- is_w  in  1  OP_32 form; ignored when XLEN==32
- src1  in  XLEN  rs1 value
- src2  in  XLEN  rs2 value
- flush  in  1  abort current operation
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  rd value
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE; in_ready=1, out_valid=0, busy=0, result=0.
  - All internal registers cleared.
  - Reset mid-operation discards the operation.
- States: IDLE, PREP, MUL, DIV, FIX, DONE.
- IDLE:
  - in_valid && in_ready accepts at that edge.
  - Operands, funct3 and is_w are latched, and N = is_w ? 32 : XLEN is latched.
  - Next state: PREP.
- PREP (1 cycle):
  - W form: take low 32 bits. Sign-extend for MULW/DIVW/REMW; zero-extend for DIVUW/REMUW.
  - Signed operands are converted to magnitudes. Result sign is recorded:
    - quotient sign = sign1 XOR sign2
    - remainder sign = sign1
    - MULH: sign1 XOR sign2; MULHSU: sign1.
  - Divide with divisor==0: go to DONE. Quotient = all ones; remainder = dividend (width-adjusted, sign-extended for W).
  - Signed divide with dividend == most-negative (width N) and divisor == -1: go to DONE. Quotient = dividend; remainder = 0.
  - Otherwise go to MUL (funct3[2]==0) or DIV (funct3[2]==1) with counter = N.
- MUL:
  - Shift-add, one multiplier bit per cycle into a 2N-bit accumulator.
  - Counter decrements; at counter==1 the next state is FIX.
- DIV:
  - Restoring division, one quotient bit per cycle, N-bit partial remainder.
  - At counter==1 the next state is FIX.
- FIX (1 cycle):
  - Apply recorded sign (two's-complement negate).
  - Select the word:
    - MUL: low N bits.
    - MULH/MULHSU/MULHU: high N bits.
    - DIV*: quotient.
    - REM*: remainder.
  - W results are sign-extended from bit 31 to XLEN.
  - Register result; go to DONE.
- DONE:
  - out_valid=1; result is held stable.
  - out_valid && out_ready at an edge leads to IDLE, with out_valid low the next cycle.
  - A new request cannot be accepted in the same cycle as the result handshake.
- Latency, counting edges after the accepting edge:
  - Normal ops: out_valid is high after edge N+2 (PREP + N iterations + FIX).
  - Special divide cases: out_valid is high after edge 1.
- flush:
  - In any non-IDLE state, the next state is IDLE and out_valid drops at that edge.
  - Flush has priority over the out_ready handshake and over completion.
  - Flush in IDLE has priority over in_valid: nothing is accepted.
- in_valid while busy is ignored; the requester holds the request.
- result is undefined-free: it holds its last registered value outside DONE.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: in MUL, when the remaining unshifted multiplier bits are all zero, the accumulator is aligned by the remaining count in one step and the unit goes to FIX. Latency is data-dependent; minimum is after edge 3 for multiplier 0 or 1.
- Undefined: MUL always takes exactly N iteration cycles. Division is unaffected either way.

Test Plan (all with XLEN=64):
1. MUL, src1=7, src2=0xFFFF_FFFF_FFFF_FFFD -> result 0xFFFF_FFFF_FFFF_FFEB; out_valid after edge 66; in_ready low throughout.
2. DIVU then REMU, src1=100, src2=0 -> 0xFFFF_FFFF_FFFF_FFFF, then 100; each has out_valid after edge 1.
3. DIV then REM, src1=0x8000_0000_0000_0000, src2=0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000, then 0.
4. DIVW then REMW, is_w=1, src1=0x0000_0001_FFFF_FFF9, src2=2 -> 0xFFFF_FFFF_FFFF_FFFD, then 0xFFFF_FFFF_FFFF_FFFF; out_valid after edge 34.
5. MULHU, src1=src2=0xFFFF_FFFF_FFFF_FFFF; hold out_ready low 5 cycles -> result stays 0xFFFF_FFFF_FFFF_FFFE and in_ready stays 0; on out_ready, back to IDLE next cycle.
6. DIV 1000/7 with flush at edge 10 -> out_valid never asserts and in_ready=1 next cycle. Repeat with rst pulsed low mid-op -> all outputs at reset values immediately.
